// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// HI holds the remainder and LO the quotient of the last completed divide.
// The FSM walks IDLE -> RUN (WIDTH cycles) -> FIX -> DONE, or goes straight
// from IDLE to FIX on a zero divisor.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] rem_r;       // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0] quo_r;       // dividend bits shifted out, quotient bits shifted in
  logic [WIDTH-1:0] dvs_r;       // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_r;   // untouched dividend, reported as HI on divide by zero
  logic             dvd_neg_r;
  logic             dvs_neg_r;
  logic             sgn_r;
  logic             zero_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   rem_sh_s;    // remainder after the shift, one bit wider
  logic [WIDTH:0]   diff_s;      // trial subtraction result
  logic             ge_s;        // trial subtraction did not borrow
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic             take_s;      // accept a new request this cycle

  // Magnitude of an operand; only negated for signed ops with the sign bit set.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      mag = (~v) + WIDTH'(1);
    end else begin
      mag = v;
    end
  endfunction

  // Two's complement negate, used by the sign fix-up step.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = (~v) + WIDTH'(1);
  endfunction

  // Shift/trial-subtract datapath and sign correction of the final result.
  always_comb begin
    take_s   = start & ~abort;
    rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_r};
    ge_s     = ~diff_s[WIDTH];
    if (sgn_r && (dvd_neg_r ^ dvs_neg_r)) begin
      q_fix_s = neg(quo_r);
    end else begin
      q_fix_s = quo_r;
    end
    if (sgn_r && dvd_neg_r) begin
      r_fix_s = neg(rem_r);
    end else begin
      r_fix_s = rem_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over everything else while an op is in flight.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_nxt_s = (divisor == {WIDTH{1'b0}}) ? FIX : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      RUN:     busy = 1'b1;
      FIX:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, one quotient bit per RUN cycle, result write at FIX exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      dvd_raw_r   <= {WIDTH{1'b0}};
      dvd_neg_r   <= 1'b0;
      dvs_neg_r   <= 1'b0;
      sgn_r       <= 1'b0;
      zero_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= mag(dividend, signed_op);
            dvs_r     <= mag(divisor, signed_op);
            dvd_raw_r <= dividend;
            dvd_neg_r <= signed_op & dividend[WIDTH-1];
            dvs_neg_r <= signed_op & divisor[WIDTH-1];
            sgn_r     <= signed_op;
            zero_r    <= (divisor == {WIDTH{1'b0}});
            cnt_r     <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          if (!abort) begin
            rem_r <= ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ge_s};
            cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          if (!abort) begin
            if (zero_r) begin
              lo          <= {WIDTH{1'b1}};
              hi          <= dvd_raw_r;
              div_by_zero <= 1'b1;
            end else begin
              lo          <= q_fix_s;
              hi          <= r_fix_s;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
